cc_ctx: RTL and testbench

Parametrised condition-code unit with context save/restore for the LC-3b datapath. It holds the live N/Z/P flags and computes them from a WIDTH-bit signed bus value. It also keeps a LIFO of saved flag sets for interrupt/exception entry and return (push on entry, pop on RTI). A registered branch-evaluation output lets BR resolve against the flags without a combinational path to the next-PC mux.

---
 rtl/cc_pkg.sv | 19 +
 rtl/cc_lifo.sv | 57 +++++
 rtl/cc_ctx.sv | 86 ++++++++
 tb/tb_cc_ctx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared condition-code types and flag generation for the LC-3b datapath.
// nzp_of takes a sign-extended value so one function serves any bus width.
package cc_pkg;

  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N = 3'b100;
  localparam nzp_t NZP_Z = 3'b010;
  localparam nzp_t NZP_P = 3'b001;

  localparam int CC_MAX_WIDTH = 64;

  function automatic nzp_t nzp_of(input logic signed [CC_MAX_WIDTH-1:0] data);
    if (data[CC_MAX_WIDTH-1]) return NZP_N;
    if (data == '0) return NZP_Z;
    return NZP_P;
  endfunction

endpackage

// File: rtl/cc_lifo.sv
// LIFO of saved flag contexts with a level counter.
// A push and pop together, a push when full or a pop when empty are all flagged as illegal.
module cc_lifo
  import cc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  nzp_t          wr_data,
  output nzp_t          rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          illegal
);

  logic [LW-1:0] r_level;
  nzp_t          r_mem [DEPTH];
  logic          w_wrOk;
  logic          w_rdOk;

  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign w_wrOk  = rst && push && !pop && !full;
  assign w_rdOk  = rst && pop && !push && !empty;
  assign illegal = (push && pop) || (push && full) || (pop && empty);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_level <= '0;
    end else if (w_wrOk) begin
      r_level <= r_level + LW'(1);
    end else if (w_rdOk) begin
      r_level <= r_level - LW'(1);
    end
  end

  // Slots are intentionally left unreset; only the level decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wrOk && (r_level == LW'(i))) r_mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_level == LW'(i + 1)) rd_data = r_mem[i];
    end
  end

endmodule

// File: rtl/cc_ctx.sv
// Condition-code unit: live N/Z/P flags, saved-context LIFO, sticky error and a
// registered branch result so BR never sees a combinational path from the flags.
module cc_ctx
  import cc_pkg::*;
#(
  parameter int   WIDTH     = 16,
  parameter int   DEPTH     = 4,
  parameter nzp_t RESET_NZP = 3'b010,
  localparam int  LW        = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_cc,
  input  logic signed [WIDTH-1:0] data,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    br_eval,
  input  logic [2:0]              br_nzp,
  input  logic                    clr_err,
  output logic                    n,
  output logic                    z,
  output logic                    p,
  output logic                    br_taken,
  output logic [LW-1:0]           level,
  output logic                    full,
  output logic                    empty,
  output logic                    err
);

  nzp_t r_nzp;
  logic r_err;
  logic r_brTaken;

  nzp_t w_rdData;
  nzp_t w_ldNzp;
  logic w_empty;
  logic w_illegal;
  logic w_popWins;
  logic w_popOk;

  cc_lifo #(.DEPTH(DEPTH)) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (r_nzp),
    .rd_data (w_rdData),
    .level   (level),
    .full    (full),
    .empty   (w_empty),
    .illegal (w_illegal)
  );

  // A lone pop blocks ld_cc even when it fails on an empty LIFO.
  assign w_popWins = pop && !push;
  assign w_popOk   = w_popWins && !w_empty;
  assign w_ldNzp   = nzp_of(CC_MAX_WIDTH'(data));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_nzp <= RESET_NZP;
    end else if (w_popOk) begin
      r_nzp <= w_rdData;
    end else if (ld_cc && !w_popWins) begin
      r_nzp <= w_ldNzp;
    end
  end

  // Error set takes precedence over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err     <= 1'b0;
      r_brTaken <= 1'b0;
    end else begin
      if (w_illegal)    r_err <= 1'b1;
      else if (clr_err) r_err <= 1'b0;
      r_brTaken <= br_eval && |(br_nzp & r_nzp);
    end
  end

  assign {n, z, p} = r_nzp;
  assign br_taken  = r_brTaken;
  assign empty     = w_empty;
  assign err       = r_err;

endmodule

// File: tb/tb_cc_ctx.sv
// Scoreboard bench for cc_ctx: a queue-based reference model predicts each cycle's
// outputs, and an independent monitor compares them one cycle after the driving edge.
module tb_cc_ctx;

  localparam int         WIDTH     = 16;
  localparam int         DEPTH     = 4;
  localparam logic [2:0] RESET_NZP = 3'b010;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld_cc = 1'b0;
  logic [WIDTH-1:0]  data = '0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              br_eval = 1'b0;
  logic [2:0]        br_nzp = '0;
  logic              clr_err = 1'b0;
  logic              n, z, p, br_taken, full, empty, err;
  logic [2:0]        level;

  always #5 clk = ~clk;

  cc_ctx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_NZP(RESET_NZP)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_cc    (ld_cc),
    .data     (data),
    .push     (push),
    .pop      (pop),
    .br_eval  (br_eval),
    .br_nzp   (br_nzp),
    .clr_err  (clr_err),
    .n        (n),
    .z        (z),
    .p        (p),
    .br_taken (br_taken),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .err      (err)
  );

  typedef struct {
    logic [2:0] nzp;
    logic       brTaken;
    int         level;
    logic       err;
  } exp_t;

  exp_t       expQ[$];
  logic [2:0] mFlags = RESET_NZP;
  logic [2:0] mStack[$];
  logic       mErr = 1'b0;
  logic       mBr = 1'b0;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [2:0] refNzp(input logic [WIDTH-1:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the following edge.
  task automatic applyStimulus(input bit rstN, input bit ld, input logic [WIDTH-1:0] d,
                               input bit ps, input bit pp, input bit be,
                               input logic [2:0] bn, input bit ce);
    exp_t e;
    bit   errSet;
    @(negedge clk);
    rst = rstN; ld_cc = ld; data = d; push = ps; pop = pp;
    br_eval = be; br_nzp = bn; clr_err = ce;
    if (!rstN) begin
      mFlags = RESET_NZP;
      mStack.delete();
      mErr = 1'b0;
      mBr = 1'b0;
    end else begin
      errSet = 1'b0;
      mBr = be && ((bn & mFlags) != 3'b000);
      if (ps && pp) begin
        errSet = 1'b1;
        if (ld) mFlags = refNzp(d);
      end else if (pp) begin
        if (mStack.size() == 0) errSet = 1'b1;
        else mFlags = mStack.pop_back();
      end else begin
        if (ps) begin
          if (mStack.size() == DEPTH) errSet = 1'b1;
          else mStack.push_back(mFlags);
        end
        if (ld) mFlags = refNzp(d);
      end
      if (errSet) mErr = 1'b1;
      else if (ce) mErr = 1'b0;
    end
    e.nzp = mFlags;
    e.brTaken = mBr;
    e.level = mStack.size();
    e.err = mErr;
    expQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(1, 0, '0, 0, 0, 0, 3'b000, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("nzp", 32'({n, z, p}), 32'(e.nzp));
        checkOutput("br_taken", 32'(br_taken), 32'(e.brTaken));
        checkOutput("level", 32'(level), 32'(e.level));
        checkOutput("full", 32'(full), 32'(e.level == DEPTH));
        checkOutput("empty", 32'(empty), 32'(e.level == 0));
        checkOutput("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    int               mode;
    $display("[TB] starting cc_ctx scoreboard run");

    // Reset then loads of negative, zero and positive values.
    applyStimulus(0, 0, '0, 0, 0, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'h8000, 0, 0, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'h0000, 0, 0, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'h7FFF, 0, 0, 0, 3'b000, 0);

    // Push/pop round trip.
    applyStimulus(1, 0, '0, 1, 0, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'h8000, 0, 0, 0, 3'b000, 0);
    applyStimulus(1, 0, '0, 1, 0, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'h0000, 0, 0, 0, 3'b000, 0);
    applyStimulus(1, 0, '0, 0, 1, 0, 3'b000, 0);
    applyStimulus(1, 0, '0, 0, 1, 0, 3'b000, 0);

    // Overflow then underflow, with varied flags in the slots.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, (i % 2 == 0) ? 16'hFFFF : 16'h0003, 1, 0, 0, 3'b000, 0);
    end
    applyStimulus(1, 0, '0, 0, 0, 0, 3'b000, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, '0, 0, 1, 0, 3'b000, 0);
    applyStimulus(1, 0, '0, 0, 0, 0, 3'b000, 1);

    // Simultaneous events.
    applyStimulus(1, 1, 16'h7FFF, 0, 0, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'hFFFF, 1, 0, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'h0000, 0, 1, 0, 3'b000, 0);
    applyStimulus(1, 0, '0, 1, 0, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'h8000, 1, 1, 0, 3'b000, 0);
    applyStimulus(1, 1, 16'h0000, 0, 1, 0, 3'b000, 1);

    // Branch evaluation against flags 010.
    applyStimulus(1, 1, 16'h0000, 0, 0, 0, 3'b000, 1);
    applyStimulus(1, 0, '0, 0, 0, 1, 3'b010, 0);
    applyStimulus(1, 0, '0, 0, 0, 1, 3'b101, 0);
    applyStimulus(1, 1, 16'h0005, 0, 0, 1, 3'b010, 0);
    idle();

    // Reset mid-sequence with push and ld_cc active.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, 1, 0, 0, 3'b000, 0);
    applyStimulus(1, 0, '0, 0, 0, 1, 3'b111, 0);
    applyStimulus(0, 1, 16'h8000, 1, 0, 1, 3'b111, 0);
    idle();

    // Randomized phase; mode biases toward filling or draining the LIFO.
    for (int i = 0; i < 1500; i++) begin
      mode = (i / 100) % 3;
      case ($urandom_range(0, 4))
        0: d = 16'h0000;
        1: d = 16'h8000;
        2: d = 16'h7FFF;
        3: d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 80) != 0, $urandom_range(0, 1) == 1, d,
                    $urandom_range(0, 3) < ((mode == 0) ? 3 : 1),
                    $urandom_range(0, 3) < ((mode == 1) ? 3 : 1),
                    $urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 7) == 0);
    end

    // Let the monitor drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
